// File: rtl/alu_ctrl_if.sv
// Bundle of the ALU controller's request, ALU-drive, register-load and read-back signals.
// slave = controller side, master = requester/ALU side.
interface alu_ctrl_if #(
    parameter int N    = 8,
    parameter int NREG = 4
);
    localparam int AW = $clog2(NREG);

    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] src_a;
    logic [AW-1:0] src_b;
    logic [AW-1:0] dst;
    logic          ready;
    logic          done;

    logic          alu_enable;
    logic [2:0]    alu_mode;
    logic [N-1:0]  alu_a;
    logic [N-1:0]  alu_b;
    logic [N-1:0]  alu_out;
    logic          alu_flag_zero;
    logic          alu_flag_carry;
    logic          flag_zero;
    logic          flag_carry;

    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [N-1:0]  ext_data;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  rd_data;

    modport slave (
        input  start, op, src_a, src_b, dst,
        input  alu_out, alu_flag_zero, alu_flag_carry,
        input  ext_we, ext_addr, ext_data, rd_addr,
        output ready, done, alu_enable, alu_mode, alu_a, alu_b,
        output flag_zero, flag_carry, rd_data
    );

    modport master (
        output start, op, src_a, src_b, dst,
        output alu_out, alu_flag_zero, alu_flag_carry,
        output ext_we, ext_addr, ext_data, rd_addr,
        input  ready, done, alu_enable, alu_mode, alu_a, alu_b,
        input  flag_zero, flag_carry, rd_data
    );
endinterface

// File: rtl/alu_ctrl.sv
// Register-file sequencer for an external registered ALU: IDLE -> LOAD -> EXEC -> WB.
// Define ALU_CTRL_B2B_EN to accept a new request in WB (3-cycle issue interval).
module alu_ctrl #(
    parameter int N    = 8,
    parameter int NREG = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_ctrl_if.slave  bus
);
    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, WB} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [AW-1:0]          src_a_q, src_a_d;
    logic [AW-1:0]          src_b_q, src_b_d;
    logic [AW-1:0]          dst_q, dst_d;
    logic [NREG-1:0][N-1:0] regs_q, regs_d;
    logic [N-1:0]           alu_a_q, alu_a_d;
    logic [N-1:0]           alu_b_q, alu_b_d;
    logic [2:0]             alu_mode_q, alu_mode_d;
    logic                   done_q, done_d;
    logic                   flag_zero_q, flag_zero_d;
    logic                   flag_carry_q, flag_carry_d;
    logic                   ready;
    logic                   accept;

`ifdef ALU_CTRL_B2B_EN
    assign ready = (state_q == IDLE) || (state_q == WB);
`else
    assign ready = (state_q == IDLE);
`endif
    assign accept = bus.start && ready;

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        dst_d        = dst_q;
        regs_d       = regs_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_mode_d   = alu_mode_q;
        done_d       = 1'b0;
        flag_zero_d  = flag_zero_q;
        flag_carry_d = flag_carry_q;

        if (accept) begin
            op_d    = bus.op;
            src_a_d = bus.src_a;
            src_b_d = bus.src_b;
            dst_d   = bus.dst;
        end

        case (state_q)
            IDLE: begin
                if (accept)
                    state_d = LOAD;
                else if (bus.ext_we)
                    regs_d[bus.ext_addr] = bus.ext_data;
            end
            // A WB->LOAD issue sees the freshly written dst here, which is the forwarding path.
            LOAD: begin
                alu_a_d    = regs_q[src_a_q];
                alu_b_d    = regs_q[src_b_q];
                alu_mode_d = op_q;
                state_d    = EXEC;
            end
            EXEC: state_d = WB;
            WB: begin
                regs_d[dst_q] = bus.alu_out;
                flag_zero_d   = bus.alu_flag_zero;
                flag_carry_d  = bus.alu_flag_carry;
                done_d        = 1'b1;
                state_d       = accept ? LOAD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= '0;
            src_a_q      <= '0;
            src_b_q      <= '0;
            dst_q        <= '0;
            regs_q       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_mode_q   <= '0;
            done_q       <= 1'b0;
            flag_zero_q  <= 1'b0;
            flag_carry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            dst_q        <= dst_d;
            regs_q       <= regs_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_mode_q   <= alu_mode_d;
            done_q       <= done_d;
            flag_zero_q  <= flag_zero_d;
            flag_carry_q <= flag_carry_d;
        end
    end

    assign bus.ready      = ready;
    assign bus.done       = done_q;
    assign bus.alu_enable = (state_q == EXEC);
    assign bus.alu_mode   = alu_mode_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.flag_zero  = flag_zero_q;
    assign bus.flag_carry = flag_carry_q;
    assign bus.rd_data    = regs_q[bus.rd_addr];
endmodule

// File: tb/tb_alu_ctrl.sv
// Randomized bench for alu_ctrl: registered ALU stub plus an array-based reference register file.
// Compile with ALU_CTRL_B2B_EN to check back-to-back issue expectations.
module tb_alu_ctrl;
    localparam logic [2:0] OP_ADD = 3'd0, OP_ADC = 3'd1, OP_SUB = 3'd2, OP_INC = 3'd3,
                           OP_DEC = 3'd4, OP_AND = 3'd5, OP_OR  = 3'd6, OP_XOR = 3'd7;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   mref [4];
    logic mz, mc;

    always #5 clk = ~clk;

    alu_ctrl_if #(.N(8), .NREG(4)) bus ();
    alu_ctrl #(.N(8), .NREG(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // {carry, result}; carry is borrow for SUB/DEC, zero for logic ops
    function automatic logic [8:0] alu_fn(input logic [2:0] m, input int a, input int b, input logic cin);
        int   s;
        logic c;
        c = 1'b0;
        case (m)
            OP_ADD:  begin s = a + b;       c = (s > 255); end
            OP_ADC:  begin s = a + b + int'(cin); c = (s > 255); end
            OP_SUB:  begin s = a - b;       c = (a < b);   end
            OP_INC:  begin s = a + 1;       c = (s > 255); end
            OP_DEC:  begin s = a - 1;       c = (a == 0);  end
            OP_AND:  s = a & b;
            OP_OR:   s = a | b;
            default: s = a ^ b;
        endcase
        return {c, s[7:0]};
    endfunction

    // ALU stub: result registered on the enable cycle, carry kept for ADC
    logic       alu_c_st;
    logic [8:0] alu_nx;
    assign alu_nx = alu_fn(bus.alu_mode, int'(bus.alu_a), int'(bus.alu_b), alu_c_st);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_out <= '0; bus.alu_flag_zero <= 1'b0; bus.alu_flag_carry <= 1'b0; alu_c_st <= 1'b0;
        end else if (bus.alu_enable) begin
            bus.alu_out        <= alu_nx[7:0];
            bus.alu_flag_zero  <= (alu_nx[7:0] == 8'd0);
            bus.alu_flag_carry <= alu_nx[8];
            alu_c_st           <= alu_nx[8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs(input string tag);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rd_addr = 2'(i);
            #1 chk(tag, bus.rd_data, mref[i]);
        end
    endtask

    task automatic ext_load(input int a, input int d);
        @(negedge clk);
        bus.ext_we = 1'b1; bus.ext_addr = 2'(a); bus.ext_data = 8'(d);
        @(posedge clk); #1;
        bus.ext_we = 1'b0;
        mref[a] = d & 255;
    endtask

    task automatic apply_model(input logic [2:0] o, input int sa, input int sb, input int d);
        logic [8:0] r;
        r = alu_fn(o, mref[sa], mref[sb], mc);
        mref[d] = int'(r[7:0]);
        mz = (r[7:0] == 8'd0);
        mc = r[8];
    endtask

    task automatic do_op(input logic [2:0] o, input int sa, input int sb, input int d);
        int n;
        @(negedge clk);
        chk("ready_idle", bus.ready, 1'b1);
        bus.start = 1'b1; bus.op = o; bus.src_a = 2'(sa); bus.src_b = 2'(sb); bus.dst = 2'(d);
        bus.rd_addr = 2'(d);
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 12) begin
            if (n == 2) chk("en_exec", bus.alu_enable, 1'b1);
            if (n == 3) chk("rd_old", bus.rd_data, mref[d]);
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, 4);
        apply_model(o, sa, sb, d);
        chk("rd_new", bus.rd_data, mref[d]);
        chk("fz", bus.flag_zero, mz);
        chk("fc", bus.flag_carry, mc);
        @(posedge clk); #1;
        chk("done_pulse", bus.done, 1'b0);
    endtask

    initial begin
        int nd, first, second;
        rst_n = 1'b0;
        bus.start = 0; bus.op = 0; bus.src_a = 0; bus.src_b = 0; bus.dst = 0;
        bus.ext_we = 0; bus.ext_addr = 0; bus.ext_data = 0; bus.rd_addr = 0;
        foreach (mref[i]) mref[i] = 0;
        mz = 0; mc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_en", bus.alu_enable, 1'b0);
        chk("rst_alu", {bus.alu_mode, bus.alu_a, bus.alu_b}, 0);
        chk("rst_flags", {bus.flag_zero, bus.flag_carry}, 0);
        check_regs("rst_reg");

        // directed: simple add, wrap to zero with carry, then ADC consuming that carry
        ext_load(0, 8'h05); ext_load(1, 8'h03);
        do_op(OP_ADD, 0, 1, 2);
        chk("add_r2", mref[2], 8'h08);
        ext_load(0, 8'hFF); ext_load(1, 8'h01);
        do_op(OP_ADD, 0, 1, 3);
        chk("wrap_z", bus.flag_zero, 1'b1);
        do_op(OP_ADC, 1, 1, 0);
        chk("adc_r0", mref[0], 8'h03);
        check_regs("dir_reg");

        // ignored traffic: ext_we with start, ext_we in LOAD, start in EXEC
        ext_load(1, 8'h20); ext_load(2, 8'h05);
        @(negedge clk);
        bus.start = 1; bus.op = OP_SUB; bus.src_a = 1; bus.src_b = 2; bus.dst = 3;
        bus.ext_we = 1; bus.ext_addr = 0; bus.ext_data = 8'h77;
        @(posedge clk); #1;
        bus.start = 0; bus.ext_addr = 3; bus.ext_data = 8'hAA;
        chk("ready_load", bus.ready, 1'b0);
        chk("en_load", bus.alu_enable, 1'b0);
        @(posedge clk); #1;
        bus.ext_we = 0;
        chk("alu_a", bus.alu_a, 8'h20);
        chk("alu_b", bus.alu_b, 8'h05);
        chk("alu_mode", bus.alu_mode, OP_SUB);
        bus.start = 1; bus.op = OP_ADD; bus.src_a = 0; bus.src_b = 0; bus.dst = 0;
        @(posedge clk); #1;
        bus.start = 0;
        nd = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done) nd++;
            @(posedge clk); #1;
        end
        chk("ign_ndone", nd, 1);
        apply_model(OP_SUB, 1, 2, 3);
        check_regs("ign_reg");

        // randomized ops and loads against the reference register file
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0)
                ext_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            else
                do_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        check_regs("rnd_reg");

        // reset during EXEC aborts the writeback
        ext_load(2, 8'h10); ext_load(3, 8'h01);
        @(negedge clk);
        bus.start = 1; bus.op = OP_SUB; bus.src_a = 2; bus.src_b = 3; bus.dst = 1;
        @(posedge clk); #1;
        bus.start = 0;
        @(posedge clk); #1;
        chk("rst_exec_en", bus.alu_enable, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_en", bus.alu_enable, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        foreach (mref[i]) mref[i] = 0;
        mz = 0; mc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_ready", bus.ready, 1'b1);
        nd = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.done) nd++;
            @(posedge clk); #1;
        end
        chk("arst_ndone", nd, 0);
        check_regs("arst_reg");

        // second INC offered during WB of the first
        ext_load(0, 8'h07);
        @(negedge clk);
        bus.start = 1; bus.op = OP_INC; bus.src_a = 0; bus.src_b = 0; bus.dst = 0;
        @(posedge clk); #1;
        bus.start = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        nd = 0; first = -1; second = -1;
        for (int k = 0; k < 10; k++) begin
            if (bus.done) begin
                if (nd == 0) first = k; else second = k;
                nd++;
            end
            @(posedge clk); #1;
        end
        apply_model(OP_INC, 0, 0, 0);
`ifdef ALU_CTRL_B2B_EN
        apply_model(OP_INC, 0, 0, 0);
        chk("b2b_ndone", nd, 2);
        chk("b2b_gap", second - first, 3);
        chk("b2b_r0", mref[0], 8'h09);
`else
        chk("b2b_ndone", nd, 1);
        chk("b2b_first", first, 0);
        chk("b2b_r0", mref[0], 8'h08);
`endif
        check_regs("b2b_reg");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter N, default 8, is the datapath width and SHALL match the ALU width.
REQ-002 Parameter NREG, default 4, is the register count, power of two, with address width $clog2(NREG).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request one operation; sampled on posedge.
REQ-006 op  in  3  ALU mode code (ADD, ADC, SUB, INC, DEC, AND, OR, XOR codes from the parameters include).
REQ-007 src_a, src_b, dst  in  log2(NREG) each  operand and destination register indices.
REQ-008 ready  out  1  high when start will be accepted this cycle.
REQ-009 done  out  1  one-cycle pulse on operation completion.
REQ-010 alu_enable  out  1; alu_mode  out  3; alu_a, alu_b  out  N  ALU drive.
REQ-011 alu_out  in  N; alu_flag_zero, alu_flag_carry  in  1  ALU results, registered inside the ALU.
REQ-012 flag_zero, flag_carry  out  1  flags latched at writeback.
REQ-013 ext_we  in  1; ext_addr  in  log2(NREG); ext_data  in  N  external register load.
REQ-014 rd_addr  in  log2(NREG); rd_data  out  N  combinational register read.

Function
REQ-015 FSM states IDLE, LOAD, EXEC, WB; ready = (state==IDLE).
REQ-016 IDLE: start=1 at edge E0 -> LOAD; op, src_a, src_b, dst captured at E0.
REQ-017 LOAD: at E1, alu_a<=reg[src_a], alu_b<=reg[src_b], alu_mode<=op; -> EXEC.
REQ-018 EXEC: alu_enable=1 for exactly this cycle; at E2 -> WB.
REQ-019 WB: at E3, reg[dst]<=alu_out, flag_zero<=alu_flag_zero, flag_carry<=alu_flag_carry, done<=1; -> IDLE.
REQ-020 done high only during the cycle after E3; total start-to-done latency 4 cycles.
REQ-021 start while not ready is ignored; captured op/indices are held stable until WB completes.
REQ-022 alu_a, alu_b, alu_mode hold their values outside LOAD; alu_enable=0 in all states except EXEC.
REQ-023 ext_we is honoured only in IDLE with start=0; reg[ext_addr]<=ext_data at that edge.
REQ-024 ext_we in any other state, or together with start in IDLE, is dropped with no side effect.
REQ-025 src_a==src_b is legal; dst may equal either source, and the write occurs only at E3.
REQ-026 Results wrap modulo 2^N; carry/borrow is taken only from alu_flag_carry.
REQ-027 rd_addr==dst during the E3 edge: rd_data shows the old value before E3 and the new value after.

Reset
REQ-028 rst_n low: state=IDLE, every register=0, alu_a=alu_b=0, alu_mode=0, alu_enable=0, done=0, flag_zero=0, flag_carry=0, asynchronously.
REQ-029 Reset mid-operation aborts with no register write; ready=1 on the first cycle after rst_n rises.

Configuration
REQ-030 Macro ALU_CTRL_B2B_EN enables back-to-back issue.
REQ-031 Defined: ready is also high in WB; start in WB goes WB->LOAD, and the WB writeback still occurs.
REQ-032 Defined: in that LOAD, a source equal to the previous dst takes the written value (forwarding), giving a 3-cycle issue interval.
REQ-033 Undefined: behaviour exactly per REQ-015..021, with a 4-cycle minimum issue interval.

Verification
REQ-034 Load r0=0x05, r1=0x03; ADD src 0,1 dst 2 -> done 4 cycles after start; r2=0x08; zero=0; carry=0.
REQ-035 r0=0xFF, r1=0x01; ADD dst 3 -> r3=0x00, flag_zero=1, flag_carry=1; then ADC r1,r1 dst 0 -> r0=0x03.
REQ-036 start pulsed during EXEC, and ext_we during LOAD -> both ignored; exactly one done; target register unchanged.
REQ-037 rst_n low during EXEC of SUB r2=0x10 -> all regs 0, no done, alu_enable=0, ready=1 after release.
REQ-038 ALU_CTRL_B2B_EN: INC r0(0x07)->r0, then start in WB with INC r0->r0 -> r0=0x09; done pulses 3 cycles apart.
REQ-039 Without macro, same stimulus: second start in WB ignored; r0=0x08.
